// File: rtl/alu_seq_bcd.sv
// alu_seq_bcd: handshaked 6502-style ALU.
// Binary ops in one cycle, decimal ADD/SUB nibble-serial.
module alu_seq_bcd #(
  parameter int WIDTH  = 8,
  parameter bit BCD_EN = 1'b1
) (
  input  logic             phi1,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [7:0]       status_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [7:0]       status_out,
  output logic             busy
);

  localparam int ND = WIDTH / 4;
  localparam int DW = (ND > 1) ? $clog2(ND) : 1;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_ASL = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_ROL = 4'h7;
  localparam logic [3:0] OP_ROR = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    BCD_ADJ,
    DONE
  } state_t;

  state_t state, nxt;

  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r, res_r;
  logic [7:0]       st_r;
  logic [7:1]       flg_r;
  logic [DW-1:0]    dig;
  logic             cy;

  logic             dec, last;

  logic [WIDTH-1:0] bin_r, bop;
  logic [WIDTH:0]   sum;
  logic [7:0]       bin_st;
  logic             cin, c_new, v_new;
  logic             t_nz, t_c, t_v;

  logic [3:0]       an, bn, nib;
  logic [4:0]       dsum;
  logic [5:0]       ddif;
  logic             dcy;
  logic [WIDTH-1:0] res_nx;

  assign dec = BCD_EN && st_r[3] &&
               (op_r == OP_ADD || op_r == OP_SUB);
  assign last = (dig == DW'(ND - 1));

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // Binary result and flags from the latched operands.
  always_comb begin
    bin_r = a_r;
    bop   = b_r;
    cin   = st_r[0];
    sum   = '0;
    c_new = st_r[0];
    v_new = st_r[6];
    t_nz  = 1'b0;
    t_c   = 1'b0;
    t_v   = 1'b0;
    case (op_r)
      OP_ADD, OP_SUB, OP_CMP: begin
        bop   = (op_r == OP_ADD) ? b_r : ~b_r;
        cin   = (op_r == OP_CMP) ? 1'b1 : st_r[0];
        sum   = {1'b0, a_r} + {1'b0, bop}
              + {{WIDTH{1'b0}}, cin};
        bin_r = sum[WIDTH-1:0];
        c_new = sum[WIDTH];
        v_new = (a_r[WIDTH-1] == bop[WIDTH-1]) &&
                (bin_r[WIDTH-1] != a_r[WIDTH-1]);
        t_nz  = 1'b1;
        t_c   = 1'b1;
        t_v   = (op_r != OP_CMP);
      end
      OP_AND: begin
        bin_r = a_r & b_r;
        t_nz  = 1'b1;
      end
      OP_OR: begin
        bin_r = a_r | b_r;
        t_nz  = 1'b1;
      end
      OP_XOR: begin
        bin_r = a_r ^ b_r;
        t_nz  = 1'b1;
      end
      OP_ASL: begin
        bin_r = {a_r[WIDTH-2:0], 1'b0};
        c_new = a_r[WIDTH-1];
        t_nz  = 1'b1;
        t_c   = 1'b1;
      end
      OP_LSR: begin
        bin_r = {1'b0, a_r[WIDTH-1:1]};
        c_new = a_r[0];
        t_nz  = 1'b1;
        t_c   = 1'b1;
      end
      OP_ROL: begin
        bin_r = {a_r[WIDTH-2:0], st_r[0]};
        c_new = a_r[WIDTH-1];
        t_nz  = 1'b1;
        t_c   = 1'b1;
      end
      OP_ROR: begin
        bin_r = {st_r[0], a_r[WIDTH-1:1]};
        c_new = a_r[0];
        t_nz  = 1'b1;
        t_c   = 1'b1;
      end
      OP_INC: begin
        bin_r = a_r + WIDTH'(1);
        t_nz  = 1'b1;
      end
      OP_DEC: begin
        bin_r = a_r - WIDTH'(1);
        t_nz  = 1'b1;
      end
      default: ;
    endcase
    bin_st = st_r;
    if (t_nz) begin
      bin_st[7] = bin_r[WIDTH-1];
      bin_st[1] = (bin_r == '0);
    end
    if (t_c) bin_st[0] = c_new;
    if (t_v) bin_st[6] = v_new;
  end

  // One decimal digit step: carry (ADD) or borrow (SUB) in cy.
  always_comb begin
    an   = a_r[4*int'(dig) +: 4];
    bn   = b_r[4*int'(dig) +: 4];
    dsum = {1'b0, an} + {1'b0, bn} + {4'b0, cy};
    ddif = {2'b0, an} - {2'b0, bn} - {5'b0, cy};
    nib  = dsum[3:0];
    dcy  = 1'b0;
    if (op_r == OP_SUB) begin
      if ($signed(ddif) < 0) begin
        nib = ddif[3:0] - 4'd6;
        dcy = 1'b1;
      end else begin
        nib = ddif[3:0];
      end
    end else if (dsum > 5'd9) begin
      nib = dsum[3:0] + 4'd6;
      dcy = 1'b1;
    end
    res_nx = res_r;
    res_nx[4*int'(dig) +: 4] = nib;
  end

  // State register.
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = EXEC;
      EXEC:    nxt = dec ? BCD_ADJ : DONE;
      BCD_ADJ: if (last) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand capture, digit walk and result registers.
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      st_r       <= '0;
      flg_r      <= '0;
      res_r      <= '0;
      dig        <= '0;
      cy         <= 1'b0;
      dout       <= '0;
      status_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r <= op;
            a_r  <= a_in;
            b_r  <= b_in;
            st_r <= status_in;
          end
        end
        EXEC: begin
          if (dec) begin
            flg_r <= bin_st[7:1];
            cy    <= (op_r == OP_ADD) ? st_r[0] : ~st_r[0];
            dig   <= '0;
          end else begin
            dout       <= bin_r;
            status_out <= bin_st;
          end
        end
        BCD_ADJ: begin
          res_r <= res_nx;
          cy    <= dcy;
          if (last) begin
            dig        <= '0;
            dout       <= res_nx;
            status_out <= {flg_r,
                           (op_r == OP_ADD) ? dcy : ~dcy};
          end else begin
            dig <= dig + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_bcd.sv
// tb_alu_seq_bcd: random + directed checks
// against an arithmetic reference model.
module tb_alu_seq_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv, ordy;
  logic [3:0] op;
  logic [7:0] a, b, st;

  logic       d_rdy, d_ov, d_busy;
  logic [7:0] d_d, d_s;
  logic       z_rdy, z_ov, z_busy;
  logic [7:0] z_d, z_s;

  logic        w_iv, w_ordy, w_rdy, w_ov, w_busy;
  logic [3:0]  w_op;
  logic [15:0] w_a, w_b, w_d;
  logic [7:0]  w_st, w_s;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq_bcd #(.WIDTH(8), .BCD_EN(1'b1)) u_dut (
    .phi1(clk), .reset_n(rst_n),
    .in_valid(iv), .in_ready(d_rdy), .op(op),
    .a_in(a), .b_in(b), .status_in(st),
    .out_valid(d_ov), .out_ready(ordy),
    .dout(d_d), .status_out(d_s), .busy(d_busy)
  );

  alu_seq_bcd #(.WIDTH(8), .BCD_EN(1'b0)) u_nobcd (
    .phi1(clk), .reset_n(rst_n),
    .in_valid(iv), .in_ready(z_rdy), .op(op),
    .a_in(a), .b_in(b), .status_in(st),
    .out_valid(z_ov), .out_ready(ordy),
    .dout(z_d), .status_out(z_s), .busy(z_busy)
  );

  alu_seq_bcd #(.WIDTH(16), .BCD_EN(1'b1)) u_w16 (
    .phi1(clk), .reset_n(rst_n),
    .in_valid(w_iv), .in_ready(w_rdy), .op(w_op),
    .a_in(w_a), .b_in(w_b), .status_in(w_st),
    .out_valid(w_ov), .out_ready(w_ordy),
    .dout(w_d), .status_out(w_s), .busy(w_busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Reference: result, P register and latency.
  function automatic void ref_alu(
    input int w, input bit bcd, input int o,
    input int x, input int y, input int p,
    output int r, output int so, output int lat);
    int mask, msb, c, bo, s, cn, v, cy, d, xd, yd;
    bit nz, tc, tv;
    mask = (1 << w) - 1;
    msb  = 1 << (w - 1);
    c    = p & 1;
    cn   = c;
    v    = (p >> 6) & 1;
    nz   = 0; tc = 0; tv = 0;
    r    = x;
    case (o)
      0, 1, 11: begin
        bo = (o == 0) ? y : (~y & mask);
        s  = x + bo + ((o == 11) ? 1 : c);
        r  = s & mask;
        cn = (s >> w) & 1;
        v  = (((x ^ bo) & msb) == 0 &&
              ((r ^ x) & msb) != 0) ? 1 : 0;
        nz = 1; tc = 1; tv = (o != 11);
      end
      2: begin r = x & y; nz = 1; end
      3: begin r = x | y; nz = 1; end
      4: begin r = x ^ y; nz = 1; end
      5: begin
        r = (x << 1) & mask; cn = (x >> (w-1)) & 1;
        nz = 1; tc = 1;
      end
      6: begin r = x >> 1; cn = x & 1; nz = 1; tc = 1; end
      7: begin
        r = ((x << 1) | c) & mask; cn = (x >> (w-1)) & 1;
        nz = 1; tc = 1;
      end
      8: begin
        r = (x >> 1) | (c ? msb : 0); cn = x & 1;
        nz = 1; tc = 1;
      end
      9:  begin r = (x + 1) & mask; nz = 1; end
      10: begin r = (x - 1) & mask; nz = 1; end
      default: ;
    endcase
    so = p;
    if (nz)
      so = (so & 'h7D) | ((r & msb) ? 'h80 : 0)
         | ((r == 0) ? 'h02 : 0);
    if (tc) so = (so & 'hFE) | cn;
    if (tv) so = (so & 'hBF) | (v << 6);
    lat = 1;
    if (bcd && (p & 8) && o <= 1) begin
      cy = (o == 0) ? c : 1 - c;
      r  = 0;
      for (int i = 0; i < w / 4; i++) begin
        xd = (x >> (4*i)) & 15;
        yd = (y >> (4*i)) & 15;
        if (o == 0) begin
          d = xd + yd + cy;
          if (d > 9) begin d = d + 6; cy = 1; end
          else cy = 0;
        end else begin
          d = xd - yd - cy;
          if (d < 0) begin d = d - 6; cy = 1; end
          else cy = 0;
        end
        r = r | ((d & 15) << (4*i));
      end
      so  = (so & 'hFE) | ((o == 0) ? cy : 1 - cy);
      lat = 1 + w / 4;
    end
  endfunction

  // Drive one op into both 8-bit units, capture
  // their first result and compare with the model.
  task automatic txn8(input int t_op, input int t_a,
                      input int t_b, input int t_st,
                      output int gd, output int gs,
                      output int zd, output int zs);
    int er, es, el, ld, lz;
    ld = 0; lz = 0;
    gd = -1; gs = -1; zd = -1; zs = -1;
    op = t_op[3:0];
    a  = t_a[7:0];
    b  = t_b[7:0];
    st = t_st[7:0];
    ordy = 1'b1;
    iv = 1'b1;
    @(posedge clk) #1;
    iv = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk) #1;
      if (ld == 0 && d_ov) begin
        ld = k; gd = int'(d_d); gs = int'(d_s);
      end
      if (lz == 0 && z_ov) begin
        lz = k; zd = int'(z_d); zs = int'(z_s);
      end
    end
    ref_alu(8, 1'b1, t_op, t_a & 255, t_b & 255,
            t_st & 255, er, es, el);
    check($sformatf("op%0h dout", t_op), gd, er);
    check($sformatf("op%0h status", t_op), gs, es);
    check($sformatf("op%0h latency", t_op), ld, el);
    ref_alu(8, 1'b0, t_op, t_a & 255, t_b & 255,
            t_st & 255, er, es, el);
    check($sformatf("op%0h nobcd dout", t_op), zd, er);
    check($sformatf("op%0h nobcd status", t_op), zs, es);
    check($sformatf("op%0h nobcd latency", t_op), lz, el);
  endtask

  initial begin
    int gd, gs, zd, zs, er, es, el, lw, ro, ra, rb, rs;
    rst_n = 1'b0;
    iv = 1'b0; ordy = 1'b0; op = '0;
    a = '0; b = '0; st = '0;
    w_iv = 1'b0; w_ordy = 1'b0; w_op = '0;
    w_a = '0; w_b = '0; w_st = '0;
    #3;
    check("rst dout", d_d, 0);
    check("rst status", d_s, 0);
    check("rst out_valid", d_ov, 0);
    check("rst in_ready", d_rdy, 1);
    check("rst busy", d_busy, 0);
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst_n = 1'b1;
    @(posedge clk) #1;

    // Directed cases.
    txn8(0, 'h7F, 'h01, 'h00, gd, gs, zd, zs);
    check("add7f dout", gd, 'h80);
    check("add7f NVZC", gs & 'hC3, 'hC0);

    txn8(0, 'h58, 'h46, 'h09, gd, gs, zd, zs);
    check("dadd dout", gd, 'h05);
    check("dadd C", gs & 1, 1);

    txn8(1, 'h12, 'h21, 'h09, gd, gs, zd, zs);
    check("dsub dout", gd, 'h91);
    check("dsub C", gs & 1, 0);
    check("sub nobcd dout", zd, 'hF1);
    check("sub nobcd NC", zs & 'h81, 'h80);

    txn8(8, 'h01, 'h00, 'h01, gd, gs, zd, zs);
    check("ror dout", gd, 'h80);
    check("ror NZC", gs & 'h83, 'h81);

    txn8(11, 'h10, 'h10, 'h40, gd, gs, zd, zs);
    check("cmp NVZC", gs & 'hC3, 'h43);

    txn8(13, 'h3C, 'h55, 'hA5, gd, gs, zd, zs);
    check("illegal dout", gd, 'h3C);
    check("illegal status", gs, 'hA5);

    // Backpressure with in_valid held high.
    op = 4'h0; a = 8'h25; b = 8'h13; st = 8'h00;
    ordy = 1'b0;
    iv = 1'b1;
    @(posedge clk) #1;
    a = 8'hFF; b = 8'hFF; op = 4'h4; st = 8'hFF;
    @(posedge clk) #1;
    check("bp out_valid", d_ov, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk) #1;
      check("bp dout", d_d, 'h38);
      check("bp status", d_s, 'h00);
      check("bp in_ready", d_rdy, 0);
      check("bp out_valid held", d_ov, 1);
    end
    ordy = 1'b1;
    @(posedge clk) #1;
    iv = 1'b0;
    check("bp release out_valid", d_ov, 0);
    check("bp release in_ready", d_rdy, 1);
    check("bp no reaccept", d_busy, 0);
    @(posedge clk) #1;

    // Random ops, biased toward decimal ADD/SUB.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ro = int'($urandom_range(0, 1));
        rs = int'($urandom_range(0, 255)) | 8;
      end else begin
        ro = int'($urandom_range(0, 15));
        rs = int'($urandom_range(0, 255));
      end
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      txn8(ro, ra, rb, rs, gd, gs, zd, zs);
    end

    // 16-bit decimal add, then reset mid-adjust.
    w_op = 4'h0; w_a = 16'h1234; w_b = 16'h5678;
    w_st = 8'h08; w_ordy = 1'b1;
    w_iv = 1'b1;
    @(posedge clk) #1;
    w_iv = 1'b0;
    lw = 0; gd = -1; gs = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk) #1;
      if (lw == 0 && w_ov) begin
        lw = k; gd = int'(w_d); gs = int'(w_s);
      end
    end
    ref_alu(16, 1'b1, 0, 'h1234, 'h5678, 'h08,
            er, es, el);
    check("w16 dout", gd, er);
    check("w16 status", gs, es);
    check("w16 latency", lw, 5);
    check("w16 dout const", gd, 'h6912);

    w_op = 4'h1; w_a = 16'h9000; w_b = 16'h0001;
    w_st = 8'h09;
    w_iv = 1'b1;
    @(posedge clk) #1;
    w_iv = 1'b0;
    @(posedge clk) #1;
    @(posedge clk) #1;
    check("w16 busy mid", w_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("w16 async dout", w_d, 0);
    check("w16 async status", w_s, 0);
    check("w16 async out_valid", w_ov, 0);
    check("w16 async busy", w_busy, 0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    @(posedge clk) #1;
    check("w16 in_ready after", w_rdy, 1);
    check("w16 idle out_valid", w_ov, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
